addsub_exhaustive_checker: RTL and testbench
============================================

Name: addsub_exhaustive_checker

Overview:
Self-test sequencer that drives the 4-bit adder/subtractor's inputs (M, A3..A0, B3..B0) and checks its outputs (S3..S0, C, V). It replaces hand-written stimulus lists.
- Walks all 512 {M,A,B} combinations in order.
- Waits a programmable settle time per vector.
- Compares against an internal golden model.
- Reports pass/fail, error count and the first failing vector.
- Sits on the board/top level beside the DUT; the DUT itself is combinational.

Parameters:
SETTLE, 2, cycles each vector is held before DUT outputs are sampled (legal range 1..15).

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
M  out  1  mode to DUT: 0 = add, 1 = subtract.
A  out  4  operand A to DUT (A[0] drives A0).
B  out  4  operand B to DUT.
S  in  4  DUT sum/difference.
C  in  1  DUT carry out.
V  in  1  DUT signed overflow.
busy  out  1  high while a run is in progress.
done  out  1  high from run completion until the next start or reset.
pass  out  1  valid when done=1; 1 when err_count==0.
err_count  out  10  number of mismatching vectors in the current/last run (max 512, no saturation).
fail_valid  out  1  set when the first mismatch is recorded.
fail_vec  out  9  {M,A,B} of the first mismatch.
fail_got  out  6  {C,V,S} observed at the first mismatch.

Behaviour:
- Reset (rst_n=0 at a rising edge), including mid-run: state=IDLE.
  - M, A, B, err_count, fail_vec, fail_got = 0.
  - busy, done, pass, fail_valid = 0.
  - Settle counter and vector index = 0.
- States: IDLE, HOLD, CHECK, DONE.
- IDLE/DONE + start=1:
  - Clear err_count, fail_valid, fail_vec, fail_got, pass, done.
  - Load index=0 and drive {M,A,B}=0.
  - busy=1; go to HOLD with settle counter = SETTLE-1.
- start while in HOLD/CHECK is ignored.
- HOLD: M/A/B stay stable. Decrement the counter; at 0 go to CHECK.
- CHECK: sample S, C, V and compare with the golden model for the current {M,A,B}.
  - On mismatch: err_count+1. If fail_valid=0, latch fail_vec/fail_got and set fail_valid.
  - If index==511: go to DONE. busy=0, done=1, pass=(final err_count==0, including this vector).
  - Otherwise: index+1, drive the new {M,A,B} on the same edge, and return to HOLD with counter SETTLE-1.
- Vector order: index[8]=M, index[7:4]=A, index[3:0]=B, increasing.
- Golden model, 5-bit unsigned arithmetic:
  - Bx = M ? ~B : B.
  - R = A + Bx + M.
  - S = R[3:0], C = R[4]. In subtract mode C=1 means no borrow (A>=B unsigned).
  - V = (A[3]==Bx[3]) && (S[3]!=A[3]).
- Timing:
  - Each vector is presented for exactly SETTLE+1 cycles.
  - A full run takes 512*(SETTLE+1) cycles from the start edge to the DONE transition.
  - With SETTLE=2: done rises 1536 cycles after the start edge.
- Outputs M/A/B are registered; no combinational path from S/C/V to any output.
- DONE holds all results and the last vector (M=1, A=F, B=F) until start or reset.

Test Plan:
- Golden DUT model, SETTLE=2, start pulse → busy=1 next cycle; done=1 exactly 1536 cycles after the start edge; pass=1, err_count=0, fail_valid=0; final M/A/B=1/F/F.
- DUT with S0 stuck-at-0 → err_count=256, pass=0; fail_vec=0x001 (M=0,A=0,B=1), fail_got={C=0,V=0,S=0000}.
- DUT with C inverted → err_count=512; fail_vec=0x000, fail_got={C=1,V=0,S=0000}.
- DUT with V stuck-at-0 → err_count=128 (64 add + 64 subtract overflow cases); fail_vec=0x017 (M=0,A=1,B=7).
- Second start pulse 100 cycles into a run → ignored: done timing unchanged. Then rst_n=0 for 1 cycle at cycle 700 → next cycle all outputs 0, state IDLE. A new start runs a full clean pass.
- SETTLE=1 with a bench DUT model whose outputs lag inputs by 2 cycles → nonzero err_count. Same DUT with SETTLE=3 → pass=1, done after 2048 cycles.

Source files
------------

// File: rtl/addsub_exhaustive_checker.sv
// Exhaustive self-test sequencer for a combinational 4-bit adder/subtractor.
// Walks all 512 {M,A,B} vectors, holds each for SETTLE+1 cycles, and checks S/C/V against a golden ripple model.
`timescale 1ns/1ps

module addsub_exhaustive_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       M,
    output logic [3:0] A,
    output logic [3:0] B,
    input  logic [3:0] S,
    input  logic       C,
    input  logic       V,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic       fail_valid,
    output logic [8:0] fail_vec,
    output logic [5:0] fail_got
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t     state_reg;
    logic [3:0] settle_reg;
    logic [8:0] vec_reg;

    // The vector register is the walk index and directly drives the DUT inputs.
    assign M = vec_reg[8];
    assign A = vec_reg[7:4];
    assign B = vec_reg[3:0];

    logic [3:0] bx;
    logic [3:0] gold_sum;
    logic [4:0] carry;
    logic       gold_v;
    logic [5:0] gold;
    logic [5:0] observed;
    logic       mismatch;
    logic [9:0] err_next;

    // Golden model: bit-level ripple of A + (B ^ M) + M.
    assign carry[0] = vec_reg[8];
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ripple
            assign bx[gi]        = vec_reg[gi] ^ vec_reg[8];
            assign gold_sum[gi]  = vec_reg[gi + 4] ^ bx[gi] ^ carry[gi];
            assign carry[gi + 1] = (vec_reg[gi + 4] & bx[gi])
                                 | (vec_reg[gi + 4] & carry[gi])
                                 | (bx[gi] & carry[gi]);
        end
    endgenerate

    assign gold_v   = (vec_reg[7] == bx[3]) && (gold_sum[3] != vec_reg[7]);
    assign gold     = {carry[4], gold_v, gold_sum};
    assign observed = {C, V, S};
    assign mismatch = (observed != gold);
    assign err_next = err_count + {9'd0, mismatch};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            settle_reg <= 4'd0;
            vec_reg    <= 9'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 10'd0;
            fail_valid <= 1'b0;
            fail_vec   <= 9'd0;
            fail_got   <= 6'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg  <= HOLD;
                        settle_reg <= SETTLE_LOAD;
                        vec_reg    <= 9'd0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= 10'd0;
                        fail_valid <= 1'b0;
                        fail_vec   <= 9'd0;
                        fail_got   <= 6'd0;
                    end
                end
                HOLD: begin
                    if (settle_reg == 4'd0) begin
                        state_reg <= CHECK;
                    end else begin
                        settle_reg <= settle_reg - 4'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= vec_reg;
                        fail_got   <= observed;
                    end
                    if (vec_reg == 9'h1FF) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (err_next == 10'd0);
                    end else begin
                        state_reg  <= HOLD;
                        settle_reg <= SETTLE_LOAD;
                        vec_reg    <= vec_reg + 9'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_exhaustive_checker.sv
// Bench for addsub_exhaustive_checker: three checker instances (SETTLE 2/1/3) against behavioural adder models,
// with fault injection and randomized corruption scored by an arithmetic reference.
`timescale 1ns/1ps

module tb_addsub_exhaustive_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] start_v;

    typedef struct packed {
        logic       m;
        logic [3:0] a;
        logic [3:0] b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [9:0] err;
        logic       fv;
        logic [8:0] fvec;
        logic [5:0] fgot;
    } obs_t;

    // Instance 2: SETTLE=2, combinational DUT model with selectable fault.
    logic       m_2, c_2, v_2, busy_2, done_2, pass_2, fv_2;
    logic [3:0] a_2, b_2, s_2;
    logic [9:0] err_2;
    logic [8:0] fvec_2;
    logic [5:0] fgot_2;
    // Instance 1: SETTLE=1, two-cycle-lag DUT model.
    logic       m_1, c_1, v_1, busy_1, done_1, pass_1, fv_1;
    logic [3:0] a_1, b_1, s_1;
    logic [9:0] err_1;
    logic [8:0] fvec_1;
    logic [5:0] fgot_1;
    // Instance 3: SETTLE=3, same lagging DUT model.
    logic       m_3, c_3, v_3, busy_3, done_3, pass_3, fv_3;
    logic [3:0] a_3, b_3, s_3;
    logic [9:0] err_3;
    logic [8:0] fvec_3;
    logic [5:0] fgot_3;

    int         fault_mode;
    logic [5:0] corrupt [512];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         sel;

    obs_t o1, o2, o3, os;
    assign o1 = '{m_1, a_1, b_1, busy_1, done_1, pass_1, err_1, fv_1, fvec_1, fgot_1};
    assign o2 = '{m_2, a_2, b_2, busy_2, done_2, pass_2, err_2, fv_2, fvec_2, fgot_2};
    assign o3 = '{m_3, a_3, b_3, busy_3, done_3, pass_3, err_3, fv_3, fvec_3, fgot_3};
    assign os = (sel == 1) ? o1 : (sel == 3) ? o3 : o2;

    addsub_exhaustive_checker #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .M(m_2), .A(a_2), .B(b_2), .S(s_2), .C(c_2), .V(v_2),
        .busy(busy_2), .done(done_2), .pass(pass_2), .err_count(err_2),
        .fail_valid(fv_2), .fail_vec(fvec_2), .fail_got(fgot_2)
    );
    addsub_exhaustive_checker #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .M(m_1), .A(a_1), .B(b_1), .S(s_1), .C(c_1), .V(v_1),
        .busy(busy_1), .done(done_1), .pass(pass_1), .err_count(err_1),
        .fail_valid(fv_1), .fail_vec(fvec_1), .fail_got(fgot_1)
    );
    addsub_exhaustive_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .M(m_3), .A(a_3), .B(b_3), .S(s_3), .C(c_3), .V(v_3),
        .busy(busy_3), .done(done_3), .pass(pass_3), .err_count(err_3),
        .fail_valid(fv_3), .fail_vec(fvec_3), .fail_got(fgot_3)
    );

    // Reference: plain integer add/subtract with signed range test for overflow. Returns {C,V,S}.
    function automatic logic [5:0] ref_out(input logic [8:0] vec);
        int a, b, sa, sb, r, sr;
        logic c, v;
        a  = {28'd0, vec[7:4]};
        b  = {28'd0, vec[3:0]};
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (vec[8] == 1'b0) begin
            r  = a + b;
            c  = (r > 15);
            sr = sa + sb;
        end else begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end
        v = (sr > 7) || (sr < -8);
        return {c, v, 4'(r)};
    endfunction

    function automatic logic [5:0] dut_out(input logic [8:0] vec, input int mode, input logic [5:0] mask);
        logic [5:0] o;
        o = ref_out(vec);
        case (mode)
            1: o[0] = 1'b0;
            2: o[5] = ~o[5];
            3: o[4] = 1'b0;
            4: o    = o ^ mask;
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        {c_2, v_2, s_2} = dut_out({m_2, a_2, b_2}, fault_mode, corrupt[{m_2, a_2, b_2}]);
    end

    logic [5:0] lag1_d1 = 6'd0, lag1_d2 = 6'd0, lag3_d1 = 6'd0, lag3_d2 = 6'd0;
    always @(posedge clk) begin
        lag1_d1 <= ref_out({m_1, a_1, b_1});
        lag1_d2 <= lag1_d1;
        lag3_d1 <= ref_out({m_3, a_3, b_3});
        lag3_d2 <= lag3_d1;
    end
    assign {c_1, v_1, s_1} = lag1_d2;
    assign {c_3, v_3, s_3} = lag3_d2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("check %s", tag);
        end
    endtask

    // Expected checker results for the current fault setup on instance 2.
    task automatic model_run(output int exp_err, output logic [8:0] exp_vec, output logic [5:0] exp_got);
        logic [5:0] g;
        logic       seen;
        exp_err = 0;
        exp_vec = 9'd0;
        exp_got = 6'd0;
        seen    = 1'b0;
        for (int v = 0; v < 512; v++) begin
            g = dut_out(9'(v), fault_mode, corrupt[v]);
            if (g != ref_out(9'(v))) begin
                exp_err++;
                if (!seen) begin
                    seen    = 1'b1;
                    exp_vec = 9'(v);
                    exp_got = g;
                end
            end
        end
    endtask

    task automatic run(input int which, input int restart_at, input int reset_at,
                       output int cycles, output bit finished);
        sel = which;
        @(negedge clk);
        start_v[which - 1] = 1'b1;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        check("busy_after_start", 64'(os.busy), 64'd1);
        cycles   = 0;
        finished = 1'b0;
        while (cycles < 6000) begin
            if (cycles == restart_at) start_v[which - 1] = 1'b1;
            if (cycles == reset_at) rst_n = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
            start_v = 3'b000;
            if (reset_at >= 0 && cycles == reset_at + 1) begin
                rst_n    = 1'b1;
                finished = 1'b1;
                break;
            end
            if (os.done) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic fault_run(input string tag);
        int         cyc, e_err;
        bit         fin;
        logic [8:0] e_vec;
        logic [5:0] e_got;
        model_run(e_err, e_vec, e_got);
        run(2, -1, -1, cyc, fin);
        $display("run %s: cycles=%0d err=%0d pass=%0d fail_vec=%03h fail_got=%02h (model err=%0d vec=%03h got=%02h)",
                 tag, cyc, o2.err, o2.pass, o2.fvec, o2.fgot, e_err, e_vec, e_got);
        check({tag, "_cycles"}, 64'(cyc), 64'd1536);
        check({tag, "_err"}, 64'(o2.err), 64'(e_err));
        check({tag, "_pass"}, 64'(o2.pass), 64'(e_err == 0));
        check({tag, "_fail_valid"}, 64'(o2.fv), 64'(e_err != 0));
        check({tag, "_fail_vec"}, 64'(o2.fvec), 64'(e_vec));
        check({tag, "_fail_got"}, 64'(o2.fgot), 64'(e_got));
        check({tag, "_last_vec"}, 64'({o2.m, o2.a, o2.b}), 64'h1FF);
    endtask

    initial begin
        int cyc;
        bit fin;
        rst_n      = 1'b0;
        start_v    = 3'b000;
        fault_mode = 0;
        sel        = 2;
        for (int v = 0; v < 512; v++) corrupt[v] = 6'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_zero_s2", 64'(o2), 64'd0);
        check("reset_zero_s1", 64'(o1), 64'd0);
        check("reset_zero_s3", 64'(o3), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_busy", 64'(o2.busy), 64'd0);

        fault_mode = 0;
        fault_run("golden");
        repeat (5) @(posedge clk);
        #1;
        check("done_held", 64'({o2.done, o2.busy, o2.m, o2.a, o2.b}), 64'({2'b10, 9'h1FF}));

        fault_mode = 1;
        fault_run("s0_stuck0");
        check("s0_stuck0_count", 64'(o2.err), 64'd256);
        fault_mode = 2;
        fault_run("c_inverted");
        check("c_inverted_count", 64'(o2.err), 64'd512);
        fault_mode = 3;
        fault_run("v_stuck0");
        check("v_stuck0_vec", 64'(o2.fvec), 64'h017);

        fault_mode = 4;
        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 512; v++)
                corrupt[v] = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            fault_run("random_corrupt");
        end
        fault_mode = 0;

        run(2, 100, -1, cyc, fin);
        $display("run restart_ignored: cycles=%0d err=%0d pass=%0d", cyc, o2.err, o2.pass);
        check("restart_cycles", 64'(cyc), 64'd1536);
        check("restart_pass", 64'(o2.pass), 64'd1);

        run(2, -1, 700, cyc, fin);
        $display("run reset_mid: cycles=%0d busy=%0d", cyc, o2.busy);
        check("midrun_reset_zero", 64'(o2), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrun_reset_idle", 64'(o2), 64'd0);
        fault_run("after_reset");

        run(1, -1, -1, cyc, fin);
        $display("run lag_settle1: cycles=%0d err=%0d pass=%0d", cyc, o1.err, o1.pass);
        check("lag1_cycles", 64'(cyc), 64'd1024);
        check("lag1_has_errors", 64'(o1.err != 10'd0), 64'd1);
        check("lag1_pass", 64'(o1.pass), 64'd0);

        run(3, -1, -1, cyc, fin);
        $display("run lag_settle3: cycles=%0d err=%0d pass=%0d", cyc, o3.err, o3.pass);
        check("lag3_cycles", 64'(cyc), 64'd2048);
        check("lag3_err", 64'(o3.err), 64'd0);
        check("lag3_pass", 64'(o3.pass), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
